// File: rtl/dmem_dma_ctrl.sv
// dmem_dma_ctrl: word-copy DMA sharing the DataMemory port with the CPU.
// The CPU always wins the port; the DMA alternates read/write on idle cycles.
module dmem_dma_ctrl #(
  parameter int MEM_WORDS = 64,
  parameter int LEN_W     = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic [31:0] config_reg,
  output logic [31:0] status_reg
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t r_state, w_next;
  logic r_start_q, r_done, r_err;
  logic [AW-1:0] r_src, r_dst, w_cfg_src, w_cfg_dst;
  logic [LEN_W-1:0] r_len, r_count, w_cfg_len, w_cnt_inc, w_src_a, w_dst_a;
  logic [LEN_W:0] w_src_end, w_dst_end;
  logic [31:0] r_data_q;
  logic w_start, w_bad, w_dma_rd, w_dma_wr, w_unused;
  assign w_cfg_src = config_reg[AW:1];
  assign w_cfg_dst = config_reg[2*AW:AW+1];
  assign w_cfg_len = config_reg[2*AW+LEN_W:2*AW+1];
  assign w_unused  = ^config_reg[31:2*AW+LEN_W+1];
  assign w_start   = config_reg[0] & ~r_start_q;
  // bounds checked one bit wider so that src+len up to 63+127 cannot wrap
  assign w_src_end = {{(LEN_W+1-AW){1'b0}}, w_cfg_src} + {1'b0, w_cfg_len};
  assign w_dst_end = {{(LEN_W+1-AW){1'b0}}, w_cfg_dst} + {1'b0, w_cfg_len};
  assign w_bad     = (w_src_end > (LEN_W+1)'(MEM_WORDS)) || (w_dst_end > (LEN_W+1)'(MEM_WORDS));
  assign w_cnt_inc = r_count + LEN_W'(1);
  assign w_src_a   = {{(LEN_W-AW){1'b0}}, r_src} + r_count;
  assign w_dst_a   = {{(LEN_W-AW){1'b0}}, r_dst} + r_count;
  assign w_dma_rd  = (r_state == RD) && !cpu_req;
  assign w_dma_wr  = (r_state == WR) && !cpu_req;
  assign cpu_rd    = mem_rd;
  assign mem_we    = cpu_req ? cpu_we : w_dma_wr;
  assign mem_a     = cpu_req  ? cpu_a :
                     w_dma_rd ? {{(30-LEN_W){1'b0}}, w_src_a, 2'b00} :
                     w_dma_wr ? {{(30-LEN_W){1'b0}}, w_dst_a, 2'b00} : 32'd0;
  assign mem_wd    = cpu_req ? cpu_wd : w_dma_wr ? r_data_q : 32'd0;
  assign status_reg = {{(29-LEN_W){1'b0}}, r_count, r_err, r_done, r_state != IDLE};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_start && !w_bad && w_cfg_len != '0) ? RD : IDLE;
      RD:      w_next = cpu_req ? RD : WR;
      WR:      w_next = cpu_req ? WR : (w_cnt_inc == r_len) ? IDLE : RD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state   <= w_next;
      r_start_q <= config_reg[0];
      if (r_state == IDLE && w_start) begin
        r_src   <= w_cfg_src;
        r_dst   <= w_cfg_dst;
        r_len   <= w_cfg_len;
        r_count <= '0;
        r_err   <= w_bad;
        r_done  <= !w_bad && w_cfg_len == '0;
      end
      if (w_dma_rd) r_data_q <= mem_rd;
      if (w_dma_wr) begin
        r_count <= w_cnt_inc;
        r_done  <= w_cnt_inc == r_len;
      end
    end
  end
endmodule

// File: tb/tb_dmem_dma_ctrl.sv
// tb_dmem_dma_ctrl: random CPU traffic and copies checked every cycle against a
// phase-counting copy model with its own shadow memory.
module tb_dmem_dma_ctrl;
  logic clk = 0, reset = 1, cpu_req = 0, cpu_we = 0, mem_we;
  logic [31:0] cpu_a = 0, cpu_wd = 0, cpu_rd, mem_a, mem_wd, mem_rd, config_reg, status_reg;
  logic [31:0] mem [64];
  logic [31:0] m_mem [64];
  int n_chk = 0, n_fail = 0, busy_cnt = 0;
  int m_src = 0, m_dst = 0, m_len = 0, m_p = 0;
  bit m_busy = 0, m_done = 0, m_err = 0, m_startq = 0;
  logic [31:0] m_data = 0;

  always #5 clk = ~clk;

  dmem_dma_ctrl dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .config_reg(config_reg), .status_reg(status_reg)
  );

  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  assign config_reg = mem[10];
  assign mem_rd = (mem_a[7:2] == 6'd11) ? status_reg : mem[mem_a[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_cfg(input int s, input int d, input int l, input bit st);
    return {12'b0, 7'(l), 6'(d), 6'(s), st};
  endfunction

  // Model: a copy of len words needs 2*len free port cycles; free cycle p reads
  // word p/2 when p is even and writes it when p is odd.
  always @(negedge clk) begin
    logic [31:0] cfg;
    if (reset) begin
      m_busy = 0; m_p = 0; m_done = 0; m_err = 0; m_startq = 0; m_data = 0;
    end
    chk("status", status_reg, {22'b0, 7'(m_p / 2), m_err, m_done, m_busy});
    chk("cpu_rd", cpu_rd, mem_rd);
    if (cpu_req) begin
      chk("mux_we", 32'(mem_we), 32'(cpu_we));
      chk("mux_a", mem_a, cpu_a);
      chk("mux_wd", mem_wd, cpu_wd);
      if (!cpu_we && cpu_a[7:2] != 6'd11) chk("cpu_load", cpu_rd, m_mem[cpu_a[7:2]]);
    end else if (m_busy) begin
      if (m_p % 2 == 0) begin
        chk("dma_rd_we", 32'(mem_we), 0);
        chk("dma_rd_a", mem_a, 32'((m_src + m_p / 2) * 4));
      end else begin
        chk("dma_wr_we", 32'(mem_we), 1);
        chk("dma_wr_a", mem_a, 32'((m_dst + m_p / 2) * 4));
        chk("dma_wr_wd", mem_wd, m_data);
      end
    end else begin
      chk("idle_we", 32'(mem_we), 0);
      chk("idle_a", mem_a, 0);
      chk("idle_wd", mem_wd, 0);
    end
    if (status_reg[0]) busy_cnt++;
    if (!reset) begin
      cfg = m_mem[10];
      if (!m_busy && cfg[0] && !m_startq) begin
        m_src = int'(cfg[6:1]); m_dst = int'(cfg[12:7]); m_len = int'(cfg[19:13]);
        m_p = 0;
        m_err = (m_src + m_len > 64) || (m_dst + m_len > 64);
        m_done = !m_err && m_len == 0;
        m_busy = !m_err && m_len != 0;
      end else if (m_busy && !cpu_req) begin
        if (m_p % 2 == 0) m_data = m_mem[m_src + m_p / 2];
        else m_mem[m_dst + m_p / 2] = m_data;
        m_p++;
        if (m_p == 2 * m_len) begin m_busy = 0; m_done = 1; end
      end
      m_startq = cfg[0];
    end
    if (cpu_req && cpu_we) m_mem[cpu_a[7:2]] = cpu_wd;
  end

  task automatic cyc(input bit rq, input bit we, input int w, input logic [31:0] d);
    cpu_req = rq; cpu_we = we; cpu_a = 32'(w * 4); cpu_wd = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  task automatic store(input int w, input logic [31:0] d);
    cyc(1, 1, w, d);
  endtask

  task automatic start_copy(input int s, input int d, input int l);
    store(10, mk_cfg(s, d, l, 0));
    store(10, mk_cfg(s, d, l, 1));
  endtask

  task automatic traffic();
    int r = $urandom_range(0, 19);
    if (r < 12) idle(1);
    else if (r < 15) cyc(1, 0, $urandom_range(12, 63), 0);
    else if (r < 19) cyc(1, 1, $urandom_range(12, 63), $urandom);
    else store(10, mk_cfg($urandom_range(12, 63), $urandom_range(12, 63),
                          $urandom_range(0, 24), 1'($urandom_range(0, 1))));
  endtask

  initial begin
    int k;
    for (int i = 0; i < 64; i++) begin mem[i] = 0; m_mem[i] = 0; end
    repeat (2) @(posedge clk);
    #1 chk("reset_status", status_reg, 0);
    reset = 0;
    // basic copy, no contention
    for (int i = 0; i < 4; i++) store(20 + i, 32'hA0 + i);
    start_copy(20, 40, 4);
    busy_cnt = 0;
    idle(12);
    chk("basic_busy_cycles", 32'(busy_cnt), 8);
    chk("basic_status", status_reg, 32'h22);
    for (int i = 0; i < 4; i++) chk("basic_data", mem[40 + i], 32'hA0 + i);
    // start held high must not retrigger
    busy_cnt = 0;
    idle(6);
    chk("held_start_no_copy", 32'(busy_cnt), 0);
    // CPU on alternate cycles starting right after the start edge
    start_copy(20, 48, 4);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 1) cyc(1, 0, 30, 0);
      else if (i % 4 == 3) store(31, 32'h5500 + i);
      else idle(1);
    end
    chk("contend_busy_cycles", 32'(busy_cnt), 16);
    chk("contend_cpu_store", mem[31], 32'h5513);
    for (int i = 0; i < 4; i++) chk("contend_data", mem[48 + i], 32'hA0 + i);
    // bounds error and zero length
    start_copy(60, 20, 8);
    idle(1);
    chk("bounds_status", status_reg, 32'h4);
    start_copy(30, 40, 0);
    idle(1);
    chk("zero_len_status", status_reg, 32'h2);
    // config rewritten mid-copy: latched src must be used
    for (int i = 0; i < 4; i++) store(24 + i, 32'hB0 + i);
    start_copy(24, 52, 4);
    idle(2);
    store(10, mk_cfg(12, 52, 4, 1));
    idle(12);
    for (int i = 0; i < 4; i++) chk("latched_src_data", mem[52 + i], 32'hB0 + i);
    // asynchronous reset after two words
    start_copy(20, 44, 4);
    k = 0;
    while (status_reg[9:3] != 7'd2 && k < 30) begin idle(1); k++; end
    chk("reach_count2", 32'(status_reg[9:3]), 2);
    #2 reset = 1;
    #1 chk("async_reset_status", status_reg, 0);
    store(10, mk_cfg(20, 44, 4, 0));
    reset = 0;
    idle(3);
    chk("reset_word0", mem[44], 32'hA0);
    chk("reset_word1", mem[45], 32'hA1);
    chk("reset_word2", mem[46], 0);
    chk("reset_word3", mem[47], 0);
    // randomized copies under random CPU traffic
    repeat (30) begin
      start_copy($urandom_range(12, 63), $urandom_range(12, 63), $urandom_range(0, 24));
      traffic();
      k = 0;
      while (status_reg[0] && k < 400) begin traffic(); k++; end
      chk("drain", 32'(status_reg[0]), 0);
    end
    idle(2);
    for (int i = 10; i < 64; i++) if (i != 11) chk("final_mem", mem[i], m_mem[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
